// File: rtl/wb_result_queue_if.sv
// wb_result_queue_if: push/drain bus between the E->M result producers, the W-stage port and the queue
//   MvalidM/MWA3M/WResultM   multiply result push (valid, destination, data)
//   FvalidM/FWA3M/FloatoutM  float result push (valid, destination, data)
//   RegWriteW                main pipeline owns the register-file write port
//   QWriteEn/QWA3/QResult    queue drain into the register-file write port
interface wb_result_queue_if #(
   parameter int DW = 32,
   parameter int AW = 4
);
   logic          MvalidM;
   logic [AW-1:0] MWA3M;
   logic [DW-1:0] WResultM;
   logic          FvalidM;
   logic [AW-1:0] FWA3M;
   logic [DW-1:0] FloatoutM;
   logic          RegWriteW;
   logic          QWriteEn;
   logic [AW-1:0] QWA3;
   logic [DW-1:0] QResult;
   modport master (
      output MvalidM, MWA3M, WResultM, FvalidM, FWA3M, FloatoutM, RegWriteW,
      input  QWriteEn, QWA3, QResult
   );
   modport slave (
      input  MvalidM, MWA3M, WResultM, FvalidM, FWA3M, FloatoutM, RegWriteW,
      output QWriteEn, QWA3, QResult
   );
endinterface

// File: rtl/wb_result_queue.sv
// wb_result_queue: FIFO of completed multiply/float results drained into the register-file write port on idle W cycles
//   CLK, Reset          clock, synchronous active-high reset
//   bus (slave)         push requests, RegWriteW, and the QWriteEn/QWA3/QResult drain port
//   RA1D, RA2D          D-stage source registers checked against queued/incoming destinations
//   PendingA, PendingB  source register still has an outstanding queued or incoming write
//   AlmostFull          fewer than 2 free entries
//   Count               current occupancy
//   Overflow            sticky: a push was dropped
module wb_result_queue #(
   parameter int DEPTH = 4,
   parameter int DW = 32,
   parameter int AW = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic          CLK,
   input  logic          Reset,
   wb_result_queue_if.slave bus,
   input  logic [AW-1:0] RA1D,
   input  logic [AW-1:0] RA2D,
   output logic          PendingA,
   output logic          PendingB,
   output logic          AlmostFull,
   output logic [CW-1:0] Count,
   output logic          Overflow
);
   logic [AW-1:0]    entryWa3 [DEPTH];
   logic [DW-1:0]    entryData [DEPTH];
   logic [DEPTH-1:0] entryValid, hitA, hitB;
   logic [PW-1:0]    rdPtr, wrPtr, fPtr;
   logic [CW-1:0]    free;
   logic             pop, acceptM, acceptF;

   assign pop = (Count != '0) & ~bus.RegWriteW;
   // the head leaving this cycle frees its slot before the pushes are checked
   assign free = CW'(DEPTH) - Count + CW'(pop);
   assign acceptM = bus.MvalidM & (free != '0);
   assign acceptF = bus.FvalidM & (free > CW'(acceptM));
   assign fPtr = wrPtr + PW'(acceptM);

   assign bus.QWriteEn = pop;
   assign bus.QWA3 = (Count != '0) ? entryWa3[rdPtr] : '0;
   assign bus.QResult = (Count != '0) ? entryData[rdPtr] : '0;
   assign AlmostFull = Count >= CW'(DEPTH - 1);

   for (genvar g = 0; g < DEPTH; g++) begin : gHit
      assign hitA[g] = entryValid[g] & (entryWa3[g] == RA1D);
      assign hitB[g] = entryValid[g] & (entryWa3[g] == RA2D);
   end

   assign PendingA = (|hitA) | (bus.MvalidM & (bus.MWA3M == RA1D)) | (bus.FvalidM & (bus.FWA3M == RA1D));
   assign PendingB = (|hitB) | (bus.MvalidM & (bus.MWA3M == RA2D)) | (bus.FvalidM & (bus.FWA3M == RA2D));

   // pop clears before the push sets, so a full-queue pop+push into the same slot stays valid
   always_ff @(posedge CLK) begin
      if (Reset) begin
         rdPtr <= '0;
         wrPtr <= '0;
         Count <= '0;
         Overflow <= 1'b0;
         entryValid <= '0;
      end else begin
         if (pop) begin
            entryValid[rdPtr] <= 1'b0;
            rdPtr <= rdPtr + PW'(1);
         end
         if (acceptM) entryValid[wrPtr] <= 1'b1;
         if (acceptF) entryValid[fPtr] <= 1'b1;
         wrPtr <= wrPtr + PW'(acceptM) + PW'(acceptF);
         Count <= Count + CW'(acceptM) + CW'(acceptF) - CW'(pop);
         if ((bus.MvalidM & ~acceptM) | (bus.FvalidM & ~acceptF)) Overflow <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!Reset && acceptM) begin
         entryWa3[wrPtr] <= bus.MWA3M;
         entryData[wrPtr] <= bus.WResultM;
      end
      if (!Reset && acceptF) begin
         entryWa3[fPtr] <= bus.FWA3M;
         entryData[fPtr] <= bus.FloatoutM;
      end
   end
endmodule
